// File: rtl/ahb_bus_pkg.sv
// rtl/ahb_bus_pkg.sv - shared AHB transfer/burst types and arbiter state encoding
package ahb_bus_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB_OPEN   = 2'd0,
    ARB_BURST  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  // Beats remaining after the NONSEQ beat; undefined-length bursts count as single.
  function automatic logic [4:0] burst_len(input hburst_e b);
    case (b)
      HB_WRAP4, HB_INCR4:   burst_len = 5'd3;
      HB_WRAP8, HB_INCR8:   burst_len = 5'd7;
      HB_WRAP16, HB_INCR16: burst_len = 5'd15;
      default:              burst_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational rotating-priority request selector
module ahb_rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_idx,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         found
);

  logic [W-1:0] cand;

  // Search upward from last_idx+1; last_idx itself is visited last so it has lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(last_idx) + i) % N);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt_idx    = cand;
        gnt[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB arbiter with fixed-burst and locked-sequence hold
module ahb_arbiter
  import ahb_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MIDX_W         = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MIDX_W-1:0]      HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MIDX_W-1:0]      DEF_IDX = MIDX_W'(DEFAULT_MASTER);

  arb_state_e             state_q, state_d, burst_state;
  logic [4:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MIDX_W-1:0]      gidx_q, gidx_d;
  logic [MIDX_W-1:0]      mast_q, mast_d;
  logic                   mlock_q, mlock_d;

  htrans_e                trans;
  hburst_e                burst;
  logic                   owner_req, owner_lock;
  logic                   last_beat, arb_pt;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [MIDX_W-1:0]      pick_idx;
  logic                   pick_found;

  assign trans      = htrans_e'(HTRANS);
  assign burst      = hburst_e'(HBURST);
  assign owner_req  = HBUSREQ[gidx_q];
  assign owner_lock = HLOCK[gidx_q];

  // Final SEQ beat of a fixed burst: the counter is about to reach zero.
  assign last_beat = (state_q == ARB_BURST) && HREADY && (trans == HT_SEQ) && (cnt_q == 5'd1);

  // BUSY beats never qualify; a stalled bus never qualifies.
  assign arb_pt = HREADY && (state_q != ARB_LOCKED) &&
                  ((trans == HT_IDLE) ||
                   ((trans == HT_NONSEQ) && (burst == HB_SINGLE)) ||
                   last_beat ||
                   ((burst == HB_INCR) && !owner_req && (trans != HT_BUSY)));

  assign burst_state = (cnt_d != 5'd0) ? ARB_BURST : ARB_OPEN;

  ahb_rr_picker #(
    .N (NUM_MASTERS),
    .W (MIDX_W)
  ) u_picker (
    .req      (HBUSREQ),
    .last_idx (gidx_q),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .found    (pick_found)
  );

  // Beat counter: load on accepted NONSEQ, count down on accepted SEQ, saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (HREADY && (trans == HT_NONSEQ)) begin
      cnt_d = burst_len(burst);
    end else if (HREADY && (trans == HT_SEQ) && (cnt_q != 5'd0)) begin
      cnt_d = cnt_q - 5'd1;
    end
  end

  // Arbitration FSM and grant selection; a locked owner keeps the bus at its arbitration point.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    case (state_q)
      ARB_LOCKED: begin
        if (HREADY && !owner_lock) state_d = burst_state;
      end
      default: begin
        state_d = burst_state;
        if (arb_pt) begin
          if (owner_lock) begin
            state_d = ARB_LOCKED;
          end else if (pick_found) begin
            grant_d = pick_gnt;
            gidx_d  = pick_idx;
          end else begin
            grant_d = DEF_GNT;
            gidx_d  = DEF_IDX;
          end
        end
      end
    endcase
  end

  // Address-phase owner follows the grant one HREADY-qualified cycle later.
  always_comb begin
    mast_d  = mast_q;
    mlock_d = mlock_q;
    if (HREADY) begin
      mast_d  = gidx_q;
      mlock_d = owner_lock;
    end
  end

  // State registers with asynchronous reset to the default-master grant.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ARB_OPEN;
      cnt_q   <= 5'd0;
      grant_q <= DEF_GNT;
      gidx_q  <= DEF_IDX;
      mast_q  <= DEF_IDX;
      mlock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      mast_q  <= mast_d;
      mlock_q <= mlock_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = mast_q;
  assign HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter
module tb_ahb_arbiter;
  import ahb_bus_pkg::*;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int n_assert = 0;
  int n_fail   = 0;

  ahb_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  logic [3:0] rot_exp [4];

  initial begin
    rot_exp = '{4'b0100, 4'b1000, 4'b0010, 4'b0100};

    HRESETn = 1'b0;
    HBUSREQ = 4'b0000;
    HLOCK   = 4'b0000;
    HTRANS  = HT_IDLE;
    HBURST  = HB_SINGLE;
    HREADY  = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_grant", 32'(HGRANT), 32'h1);
    chk("rst_master", 32'(HMASTER), 32'h0);
    chk("rst_mlock", 32'(HMASTLOCK), 32'h0);
    HRESETn = 1'b1;

    // Idle bus, no requests: default master holds.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_grant", 32'(HGRANT), 32'h1);
      chk("idle_master", 32'(HMASTER), 32'h0);
      chk("idle_mlock", 32'(HMASTLOCK), 32'h0);
    end

    // Round robin over SINGLE transfers.
    HBUSREQ = 4'b1110;
    step();
    chk("rr_first", 32'(HGRANT), 32'b0010);
    HTRANS = HT_NONSEQ;
    HBURST = HB_SINGLE;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_rotate", 32'(HGRANT), 32'(rot_exp[i]));
    end
    chk("rr_master", 32'(HMASTER), 32'h1);

    // INCR8 from master 1, master 2 requesting from beat 2.
    HBUSREQ = 4'b0010;
    HTRANS  = HT_IDLE;
    step();
    chk("b8_grant1", 32'(HGRANT), 32'b0010);
    HTRANS = HT_NONSEQ;
    HBURST = HB_INCR8;
    step();
    chk("b8_cnt_load", 32'(dut.cnt_q), 32'd7);
    chk("b8_beat1", 32'(HGRANT), 32'b0010);
    HTRANS  = HT_SEQ;
    HBUSREQ = 4'b0110;
    for (int b = 2; b <= 8; b++) begin
      step();
      chk("b8_beat", 32'(HGRANT), (b < 8) ? 32'b0010 : 32'b0100);
    end
    chk("b8_master_lag", 32'(HMASTER), 32'h1);
    HBUSREQ = 4'b0100;
    HTRANS  = HT_IDLE;
    step();
    chk("b8_master_hand", 32'(HMASTER), 32'h2);
    chk("b8_grant_keep", 32'(HGRANT), 32'b0100);

    // Same INCR8 with a 3-cycle stall on beat 5.
    HBUSREQ = 4'b0010;
    step();
    chk("st_grant1", 32'(HGRANT), 32'b0010);
    HTRANS = HT_NONSEQ;
    HBURST = HB_INCR8;
    step();
    HTRANS  = HT_SEQ;
    HBUSREQ = 4'b0110;
    repeat (3) step();
    chk("st_cnt_b4", 32'(dut.cnt_q), 32'd4);
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_frz_cnt", 32'(dut.cnt_q), 32'd4);
      chk("st_frz_grant", 32'(HGRANT), 32'b0010);
      chk("st_frz_master", 32'(HMASTER), 32'h1);
    end
    HREADY = 1'b1;
    for (int b = 5; b <= 8; b++) begin
      step();
      chk("st_beat", 32'(HGRANT), (b < 8) ? 32'b0010 : 32'b0100);
    end

    // Arbitration point suppressed by HREADY low.
    HTRANS  = HT_IDLE;
    HBUSREQ = 4'b1000;
    HREADY  = 1'b0;
    step();
    chk("hr_low_grant", 32'(HGRANT), 32'b0100);
    chk("hr_low_master", 32'(HMASTER), 32'h1);
    HREADY = 1'b1;
    step();
    chk("hr_hi_grant", 32'(HGRANT), 32'b1000);
    chk("hr_hi_master", 32'(HMASTER), 32'h2);

    // Master 3 locked sequence of two SINGLEs while 0 and 1 request.
    HLOCK   = 4'b1000;
    HBUSREQ = 4'b1011;
    step();
    chk("lk_enter_grant", 32'(HGRANT), 32'b1000);
    chk("lk_enter_master", 32'(HMASTER), 32'h3);
    chk("lk_mlock1", 32'(HMASTLOCK), 32'h1);
    HTRANS = HT_NONSEQ;
    HBURST = HB_SINGLE;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("lk_hold_grant", 32'(HGRANT), 32'b1000);
      chk("lk_hold_mlock", 32'(HMASTLOCK), 32'h1);
    end
    HLOCK   = 4'b0000;
    HTRANS  = HT_IDLE;
    HBUSREQ = 4'b0011;
    step();
    chk("lk_exit_grant", 32'(HGRANT), 32'b1000);
    chk("lk_exit_mlock", 32'(HMASTLOCK), 32'h0);
    step();
    chk("lk_next_grant", 32'(HGRANT), 32'b0001);

    // INCR: owner drops request while master 2 asserts in the same cycle.
    HBUSREQ = 4'b0001;
    HTRANS  = HT_NONSEQ;
    HBURST  = HB_INCR;
    step();
    chk("incr_hold", 32'(HGRANT), 32'b0001);
    HTRANS  = HT_SEQ;
    HBUSREQ = 4'b0100;
    step();
    chk("incr_swap", 32'(HGRANT), 32'b0100);

    // Asynchronous reset during a WRAP16.
    HTRANS = HT_NONSEQ;
    HBURST = HB_WRAP16;
    step();
    chk("w16_cnt_load", 32'(dut.cnt_q), 32'd15);
    HTRANS = HT_SEQ;
    repeat (3) step();
    chk("w16_pre_master", 32'(HMASTER), 32'h2);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_grant", 32'(HGRANT), 32'h1);
    chk("arst_master", 32'(HMASTER), 32'h0);
    chk("arst_mlock", 32'(HMASTLOCK), 32'h0);
    chk("arst_cnt", 32'(dut.cnt_q), 32'd0);
    step();
    HRESETn = 1'b1;
    HTRANS  = HT_IDLE;
    HBUSREQ = 4'b0100;
    step();
    chk("w16_regrant", 32'(HGRANT), 32'b0100);
    HTRANS  = HT_NONSEQ;
    HBURST  = HB_WRAP16;
    HBUSREQ = 4'b0101;
    step();
    chk("w16_reload", 32'(dut.cnt_q), 32'd15);
    HTRANS = HT_SEQ;
    for (int b = 2; b <= 16; b++) begin
      step();
      chk("w16_beat", 32'(HGRANT), (b < 16) ? 32'b0100 : 32'b0001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
